// File: rtl/gato_pkg.sv
// rtl/gato_pkg.sv - shared types and constants for the Gato turn controller
package gato_pkg;

    typedef enum logic [1:0] {
        TURNO  = 2'd0,
        EVALUA = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam logic [1:0] GAN_NADIE  = 2'b00;
    localparam logic [1:0] GAN_J1     = 2'b01;
    localparam logic [1:0] GAN_J2     = 2'b10;
    localparam logic [1:0] GAN_EMPATE = 2'b11;

    localparam int N_CASILLAS = 9;
    localparam int N_LINEAS   = 8;

    // Three rows, three columns, two diagonals; bit i is cell i.
    localparam logic [N_LINEAS-1:0][N_CASILLAS-1:0] LINEAS = {
        9'h054, 9'h111,
        9'h124, 9'h092, 9'h049,
        9'h1C0, 9'h038, 9'h007
    };

endpackage

// File: rtl/detector_linea.sv
// rtl/detector_linea.sv - flags a board that holds any complete line of three
module detector_linea
    import gato_pkg::*;
(
    input  logic [N_CASILLAS-1:0] tablero,
    output logic                  linea
);

    always_comb begin
        linea = 1'b0;
        for (int i = 0; i < N_LINEAS; i++) begin
            if ((tablero & LINEAS[i]) == LINEAS[i]) begin
                linea = 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_turnos.sv
// rtl/control_turnos.sv - turn arbitration, move validation and win/draw evaluation
module control_turnos
    import gato_pkg::*;
#(
    parameter int unsigned PRIMER_JUGADOR = 0,
    parameter int unsigned TIEMPO_TURNO   = 0,
    parameter int unsigned ANCHO_CONT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reiniciar_partida,
    input  logic                  j1_valido,
    input  logic [3:0]            j1_casilla,
    input  logic                  j2_valido,
    input  logic [3:0]            j2_casilla,
    output logic [N_CASILLAS-1:0] tablero_j1,
    output logic [N_CASILLAS-1:0] tablero_j2,
    output logic                  turno,
    output logic                  j1_ack,
    output logic                  j2_ack,
    output logic                  mov_invalido,
    output logic                  tiempo_agotado,
    output logic [1:0]            ganador,
    output logic                  fin_juego
);

    localparam logic TURNO_INICIAL = 1'(PRIMER_JUGADOR);
    localparam logic [ANCHO_CONT-1:0] CONT_LIMITE =
        (TIEMPO_TURNO == 0) ? '0 : ANCHO_CONT'(TIEMPO_TURNO - 1);

    estado_t               estado_q, estado_d;
    logic [N_CASILLAS-1:0] tab1_q, tab1_d, tab2_q, tab2_d;
    logic                  turno_q, turno_d;
    logic                  ack1_q, ack1_d, ack2_q, ack2_d;
    logic                  inval_q, inval_d, agotado_q, agotado_d;
    logic [1:0]            gan_q, gan_d;
    logic [ANCHO_CONT-1:0] cont_q, cont_d;

    logic                  req_valido;
    logic [3:0]            req_casilla;
    logic [N_CASILLAS-1:0] req_mascara;
    logic                  legal;
    logic                  linea_j1, linea_j2;

    detector_linea u_linea_j1 (.tablero(tab1_q), .linea(linea_j1));
    detector_linea u_linea_j2 (.tablero(tab2_q), .linea(linea_j2));

    // Only the player on turn is ever looked at; cells 9..15 give an empty mask.
    assign req_valido  = turno_q ? j2_valido  : j1_valido;
    assign req_casilla = turno_q ? j2_casilla : j1_casilla;
    assign req_mascara = N_CASILLAS'(1) << req_casilla;
    assign legal       = req_valido && (req_casilla < 4'd9) &&
                         (((tab1_q | tab2_q) & req_mascara) == '0);

    always_comb begin
        estado_d  = estado_q;
        tab1_d    = tab1_q;
        tab2_d    = tab2_q;
        turno_d   = turno_q;
        ack1_d    = 1'b0;
        ack2_d    = 1'b0;
        inval_d   = 1'b0;
        agotado_d = 1'b0;
        gan_d     = gan_q;
        cont_d    = cont_q;

        if (reiniciar_partida) begin
            estado_d = TURNO;
            tab1_d   = '0;
            tab2_d   = '0;
            turno_d  = TURNO_INICIAL;
            gan_d    = GAN_NADIE;
            cont_d   = '0;
        end else begin
            case (estado_q)
                TURNO: begin
                    if (legal) begin
                        if (turno_q) begin
                            tab2_d = tab2_q | req_mascara;
                            ack2_d = 1'b1;
                        end else begin
                            tab1_d = tab1_q | req_mascara;
                            ack1_d = 1'b1;
                        end
                        cont_d   = '0;
                        estado_d = EVALUA;
                    end else begin
                        inval_d = req_valido;
                        if (TIEMPO_TURNO != 0) begin
                            if (cont_q == CONT_LIMITE) begin
                                turno_d   = ~turno_q;
                                agotado_d = 1'b1;
                                cont_d    = '0;
                            end else begin
                                cont_d = cont_q + ANCHO_CONT'(1);
                            end
                        end
                    end
                end
                EVALUA: begin
                    // Only the player who just moved can have completed a line.
                    if (turno_q ? linea_j2 : linea_j1) begin
                        gan_d    = turno_q ? GAN_J2 : GAN_J1;
                        estado_d = FIN;
                    end else if ((tab1_q | tab2_q) == '1) begin
                        gan_d    = GAN_EMPATE;
                        estado_d = FIN;
                    end else begin
                        turno_d  = ~turno_q;
                        cont_d   = '0;
                        estado_d = TURNO;
                    end
                end
                FIN: begin
                    estado_d = FIN;
                end
                default: begin
                    estado_d = TURNO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= TURNO;
            tab1_q    <= '0;
            tab2_q    <= '0;
            turno_q   <= TURNO_INICIAL;
            ack1_q    <= 1'b0;
            ack2_q    <= 1'b0;
            inval_q   <= 1'b0;
            agotado_q <= 1'b0;
            gan_q     <= GAN_NADIE;
            cont_q    <= '0;
        end else begin
            estado_q  <= estado_d;
            tab1_q    <= tab1_d;
            tab2_q    <= tab2_d;
            turno_q   <= turno_d;
            ack1_q    <= ack1_d;
            ack2_q    <= ack2_d;
            inval_q   <= inval_d;
            agotado_q <= agotado_d;
            gan_q     <= gan_d;
            cont_q    <= cont_d;
        end
    end

    assign tablero_j1     = tab1_q;
    assign tablero_j2     = tab2_q;
    assign turno          = turno_q;
    assign j1_ack         = ack1_q;
    assign j2_ack         = ack2_q;
    assign mov_invalido   = inval_q;
    assign tiempo_agotado = agotado_q;
    assign ganador        = gan_q;
    assign fin_juego      = (estado_q == FIN);

endmodule

// File: tb/tb_control_turnos.sv
// tb/tb_control_turnos.sv - directed and randomized checks of control_turnos against a game model
module tb_control_turnos;

    localparam int T_TURNO = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reiniciar_partida = 1'b0;
    logic       j1_valido = 1'b0;
    logic [3:0] j1_casilla = 4'd0;
    logic       j2_valido = 1'b0;
    logic [3:0] j2_casilla = 4'd0;
    logic [8:0] tablero_j1, tablero_j2;
    logic       turno, j1_ack, j2_ack, mov_invalido, tiempo_agotado, fin_juego;
    logic [1:0] ganador;

    control_turnos #(
        .PRIMER_JUGADOR(0),
        .TIEMPO_TURNO  (T_TURNO),
        .ANCHO_CONT    (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .reiniciar_partida(reiniciar_partida),
        .j1_valido        (j1_valido),
        .j1_casilla       (j1_casilla),
        .j2_valido        (j2_valido),
        .j2_casilla       (j2_casilla),
        .tablero_j1       (tablero_j1),
        .tablero_j2       (tablero_j2),
        .turno            (turno),
        .j1_ack           (j1_ack),
        .j2_ack           (j2_ack),
        .mov_invalido     (mov_invalido),
        .tiempo_agotado   (tiempo_agotado),
        .ganador          (ganador),
        .fin_juego        (fin_juego)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: owner of each cell (0 free, 1 J1, 2 J2) plus the game phase.
    int   owner [9];
    int   lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    bit   m_turn, m_pending, m_over, started;
    int   m_idle;
    logic [1:0] m_gan;
    bit   e_a1, e_a2, e_inv, e_to;

    function automatic logic [8:0] board_of(input int p);
        logic [8:0] b = '0;
        for (int i = 0; i < 9; i++) if (owner[i] == p) b[i] = 1'b1;
        return b;
    endfunction

    task automatic model_step();
        int  p, c;
        bit  v, win, full;
        e_a1 = 0; e_a2 = 0; e_inv = 0; e_to = 0;
        if (reset || reiniciar_partida) begin
            for (int i = 0; i < 9; i++) owner[i] = 0;
            m_turn = 0; m_pending = 0; m_over = 0; m_idle = 0; m_gan = 2'b00;
        end else if (m_over) begin
        end else if (m_pending) begin
            p = m_turn ? 2 : 1;
            win = 0;
            for (int l = 0; l < 8; l++)
                if (owner[lines[l][0]] == p && owner[lines[l][1]] == p && owner[lines[l][2]] == p)
                    win = 1;
            full = 1;
            for (int i = 0; i < 9; i++) if (owner[i] == 0) full = 0;
            m_pending = 0;
            if (win) begin m_gan = 2'(p); m_over = 1; end
            else if (full) begin m_gan = 2'b11; m_over = 1; end
            else begin m_turn = !m_turn; m_idle = 0; end
        end else begin
            v = m_turn ? j2_valido : j1_valido;
            c = m_turn ? int'(j2_casilla) : int'(j1_casilla);
            if (v && c < 9 && owner[c] == 0) begin
                owner[c] = m_turn ? 2 : 1;
                if (m_turn) e_a2 = 1; else e_a1 = 1;
                m_pending = 1;
                m_idle = 0;
            end else begin
                if (v) e_inv = 1;
                m_idle++;
                if (m_idle == T_TURNO) begin
                    m_turn = !m_turn; e_to = 1; m_idle = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step();
        if (reset) started = 1;
        #1;
        if (started) begin
            chk("cyc_tablero_j1", tablero_j1, board_of(1));
            chk("cyc_tablero_j2", tablero_j2, board_of(2));
            chk("cyc_turno", turno, m_turn);
            chk("cyc_j1_ack", j1_ack, e_a1);
            chk("cyc_j2_ack", j2_ack, e_a2);
            chk("cyc_mov_invalido", mov_invalido, e_inv);
            chk("cyc_tiempo_agotado", tiempo_agotado, e_to);
            chk("cyc_ganador", ganador, m_gan);
            chk("cyc_fin_juego", fin_juego, m_over);
        end
    end

    task automatic restart();
        j1_valido = 0; j2_valido = 0;
        reiniciar_partida = 1;
        @(negedge clk);
        reiniciar_partida = 0;
    endtask

    task automatic play(input bit p, input int c);
        if (p) begin j2_valido = 1; j2_casilla = 4'(c); end
        else   begin j1_valido = 1; j1_casilla = 4'(c); end
        @(negedge clk);
        j1_valido = 0; j2_valido = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 0;
        chk("reset_tab1", tablero_j1, 9'h000);
        chk("reset_tab2", tablero_j2, 9'h000);
        chk("reset_turno", turno, 1'b0);
        chk("reset_ganador", ganador, 2'b00);
        chk("reset_fin", fin_juego, 1'b0);

        j1_valido = 1; j1_casilla = 4;
        @(negedge clk);
        chk("first_j1_ack", j1_ack, 1'b1);
        chk("first_tab1", tablero_j1, 9'h010);
        chk("first_turno_still0", turno, 1'b0);
        j1_valido = 0;
        @(negedge clk);
        chk("first_turno", turno, 1'b1);
        j1_valido = 1; j1_casilla = 0;
        @(negedge clk);
        chk("ignored_j1_ack", j1_ack, 1'b0);
        chk("ignored_inval", mov_invalido, 1'b0);
        j1_valido = 0;
        j2_valido = 1; j2_casilla = 4;
        @(negedge clk);
        chk("occupied_inval", mov_invalido, 1'b1);
        chk("occupied_tab2", tablero_j2, 9'h000);
        j2_casilla = 12;
        @(negedge clk);
        chk("range_inval", mov_invalido, 1'b1);
        chk("range_turno", turno, 1'b1);
        chk("range_tab1", tablero_j1, 9'h010);
        j2_valido = 0;
        @(negedge clk);
        restart();

        play(0, 0); play(1, 3); play(0, 1); play(1, 4); play(0, 2);
        chk("win_ganador", ganador, 2'b01);
        chk("win_fin", fin_juego, 1'b1);
        j2_valido = 1; j2_casilla = 5;
        @(negedge clk);
        chk("fin_j2_ack", j2_ack, 1'b0);
        chk("fin_tab2", tablero_j2, 9'h018);
        j2_valido = 0;
        restart();

        play(0, 0); play(1, 1); play(0, 2); play(1, 4); play(0, 3);
        play(1, 5); play(0, 7); play(1, 6); play(0, 8);
        chk("draw_ganador", ganador, 2'b11);
        chk("draw_full", tablero_j1 | tablero_j2, 9'h1FF);
        chk("draw_tab1", tablero_j1, 9'h18D);
        restart();

        play(0, 0); play(1, 1); play(0, 2); play(1, 3); play(0, 4);
        play(1, 5); play(0, 7); play(1, 6); play(0, 8);
        chk("ninth_win_ganador", ganador, 2'b01);
        chk("ninth_win_full", tablero_j1 | tablero_j2, 9'h1FF);
        restart();

        repeat (4) @(negedge clk);
        chk("to_not_yet", tiempo_agotado, 1'b0);
        @(negedge clk);
        chk("to_pulse", tiempo_agotado, 1'b1);
        chk("to_turno", turno, 1'b1);
        restart();

        repeat (4) @(negedge clk);
        j1_valido = 1; j1_casilla = 4;
        @(negedge clk);
        chk("expiry_move_ack", j1_ack, 1'b1);
        chk("expiry_move_no_to", tiempo_agotado, 1'b0);
        j1_valido = 0;
        @(negedge clk);
        chk("expiry_move_turno", turno, 1'b1);
        restart();

        j1_valido = 1; j1_casilla = 4; j2_valido = 1; j2_casilla = 5;
        @(negedge clk);
        chk("both_j1_ack", j1_ack, 1'b1);
        chk("both_j2_ack", j2_ack, 1'b0);
        chk("both_tab2", tablero_j2, 9'h000);
        j1_valido = 0; j2_valido = 0;
        reiniciar_partida = 1;
        @(negedge clk);
        reiniciar_partida = 0;
        chk("reeval_tab1", tablero_j1, 9'h000);
        chk("reeval_ganador", ganador, 2'b00);
        chk("reeval_turno", turno, 1'b0);

        repeat (4000) begin
            @(negedge clk);
            j1_valido  = ($urandom_range(0, 99) < 40);
            j2_valido  = ($urandom_range(0, 99) < 40);
            j1_casilla = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            j2_casilla = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            reiniciar_partida = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        j1_valido = 0; j2_valido = 0; reiniciar_partida = 0; reset = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
